// File: rtl/commit_trace.sv
// commit_trace: captures retired register/memory writes into a show-ahead trace FIFO.
// Optional build macro COMMIT_TRACE_TS_EN adds a free-running 16-bit timestamp per entry.
module commit_trace #(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     commit_valid,
  input  logic [11:0]              commit_pc,
  input  logic                     rf_we,
  input  logic [4:0]               rf_reg,
  input  logic [31:0]              rf_data,
  input  logic                     mem_we,
  input  logic [11:0]              mem_addr,
  input  logic [31:0]              mem_data,
  input  logic                     trace_ready,
  output logic                     trace_valid,
  output logic [1:0]               trace_kind,
  output logic [11:0]              trace_pc,
  output logic [11:0]              trace_dst,
  output logic [31:0]              trace_data,
  output logic [15:0]              trace_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [7:0]               drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
  localparam logic [1:0]  KIND_REG  = 2'b01;
  localparam logic [1:0]  KIND_MEM  = 2'b10;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t        state;
  logic [11:0]   pend_pc;
  logic [11:0]   pend_addr;
  logic [31:0]   pend_data;
  logic [15:0]   pend_ts;
  logic [15:0]   ts;

  logic [1:0]    fifo_kind [DEPTH];
  logic [11:0]   fifo_pc   [DEPTH];
  logic [11:0]   fifo_dst  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
`ifdef COMMIT_TRACE_TS_EN
  logic [15:0]   fifo_ts   [DEPTH];
`endif
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          accept, has_reg, has_mem, discard;
  logic          push_req, push_do, pop, overflow, bypass;
  logic [1:0]    push_kind;
  logic [11:0]   push_pc, push_dst;
  logic [31:0]   push_data;
  logic [15:0]   push_ts;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count_next;
  logic [1:0]    lost;
  logic [8:0]    drop_sum;
  logic [1:0]    head_kind;
  logic [11:0]   head_pc, head_dst;
  logic [31:0]   head_data;
  logic [15:0]   head_ts;

`ifdef COMMIT_TRACE_TS_EN
  // Free-running timestamp; clear deliberately leaves it alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts <= 16'd0;
    end else begin
      ts <= ts + 16'd1;
    end
  end
`else
  assign ts = 16'd0;
`endif

  // Decode which entry (if any) is offered to the FIFO this cycle.
  always_comb begin
    accept    = commit_valid & enable;
    has_reg   = rf_we & (rf_reg != 5'd0);
    has_mem   = mem_we;
    push_req  = 1'b0;
    push_kind = 2'b00;
    push_pc   = 12'd0;
    push_dst  = 12'd0;
    push_data = 32'd0;
    push_ts   = 16'd0;
    discard   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && has_reg) begin
          push_req  = 1'b1;
          push_kind = KIND_REG;
          push_pc   = commit_pc;
          push_dst  = {7'd0, rf_reg};
          push_data = rf_data;
          push_ts   = ts;
        end else if (accept && has_mem) begin
          push_req  = 1'b1;
          push_kind = KIND_MEM;
          push_pc   = commit_pc;
          push_dst  = mem_addr;
          push_data = mem_data;
          push_ts   = ts;
        end else begin
          push_req  = 1'b0;
        end
      end
      PEND: begin
        // The deferred mem half always goes out; a new commit here is lost.
        push_req  = 1'b1;
        push_kind = KIND_MEM;
        push_pc   = pend_pc;
        push_dst  = pend_addr;
        push_data = pend_data;
        push_ts   = pend_ts;
        discard   = accept & (has_reg | has_mem);
      end
      default: begin
        push_req  = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping and next head entry (bypassed when it is written this edge).
  always_comb begin
    pop        = trace_valid & trace_ready;
    overflow   = push_req & full & ~pop;
    push_do    = push_req & ~overflow;
    rd_next    = rd_ptr + {{(AW-1){1'b0}}, pop};
    count_next = count + {{AW{1'b0}}, push_do} - {{AW{1'b0}}, pop};
    lost       = {1'b0, overflow} + {1'b0, discard};
    drop_sum   = {1'b0, drop_count} + {7'd0, lost};
    bypass     = push_do & (rd_next == wr_ptr);
    if (count_next == {(AW+1){1'b0}}) begin
      head_kind = 2'b00;
      head_pc   = 12'd0;
      head_dst  = 12'd0;
      head_data = 32'd0;
      head_ts   = 16'd0;
    end else if (bypass) begin
      head_kind = push_kind;
      head_pc   = push_pc;
      head_dst  = push_dst;
      head_data = push_data;
      head_ts   = push_ts;
    end else begin
      head_kind = fifo_kind[rd_next];
      head_pc   = fifo_pc[rd_next];
      head_dst  = fifo_dst[rd_next];
      head_data = fifo_data[rd_next];
`ifdef COMMIT_TRACE_TS_EN
      head_ts   = fifo_ts[rd_next];
`else
      head_ts   = 16'd0;
`endif
    end
  end

  // Two-state commit FSM: PEND holds the mem half of a dual-write commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pend_pc   <= 12'd0;
      pend_addr <= 12'd0;
      pend_data <= 32'd0;
      pend_ts   <= 16'd0;
    end else if (clear) begin
      state     <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept && has_reg && has_mem) begin
            state     <= PEND;
            pend_pc   <= commit_pc;
            pend_addr <= mem_addr;
            pend_data <= mem_data;
            pend_ts   <= ts;
          end
        end
        PEND:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clock) begin
    if (push_do && !clear) begin
      fifo_kind[wr_ptr] <= push_kind;
      fifo_pc[wr_ptr]   <= push_pc;
      fifo_dst[wr_ptr]  <= push_dst;
      fifo_data[wr_ptr] <= push_data;
`ifdef COMMIT_TRACE_TS_EN
      fifo_ts[wr_ptr]   <= push_ts;
`endif
    end
  end

  // Pointers, occupancy, drop counter and registered head outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= {AW{1'b0}};
      rd_ptr      <= {AW{1'b0}};
      count       <= {(AW+1){1'b0}};
      full        <= 1'b0;
      drop_count  <= 8'd0;
      trace_valid <= 1'b0;
      trace_kind  <= 2'b00;
      trace_pc    <= 12'd0;
      trace_dst   <= 12'd0;
      trace_data  <= 32'd0;
      trace_ts    <= 16'd0;
    end else if (clear) begin
      wr_ptr      <= {AW{1'b0}};
      rd_ptr      <= {AW{1'b0}};
      count       <= {(AW+1){1'b0}};
      full        <= 1'b0;
      drop_count  <= 8'd0;
      trace_valid <= 1'b0;
      trace_kind  <= 2'b00;
      trace_pc    <= 12'd0;
      trace_dst   <= 12'd0;
      trace_data  <= 32'd0;
      trace_ts    <= 16'd0;
    end else begin
      wr_ptr      <= wr_ptr + {{(AW-1){1'b0}}, push_do};
      rd_ptr      <= rd_next;
      count       <= count_next;
      full        <= (count_next == DEPTH_CNT);
      drop_count  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      trace_valid <= (count_next != {(AW+1){1'b0}});
      trace_kind  <= head_kind;
      trace_pc    <= head_pc;
      trace_dst   <= head_dst;
      trace_data  <= head_data;
      trace_ts    <= head_ts;
    end
  end

endmodule

// File: tb/tb_commit_trace.sv
// Self-checking bench for commit_trace: vector table plus scoreboard queue of expected trace entries.
module tb_commit_trace;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable, clear, commit_valid, rf_we, mem_we, trace_ready;
  logic [11:0] commit_pc, mem_addr;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data, mem_data;
  logic        trace_valid, full;
  logic [1:0]  trace_kind;
  logic [11:0] trace_pc, trace_dst;
  logic [31:0] trace_data;
  logic [15:0] trace_ts;
  logic [4:0]  count;
  logic [7:0]  drop_count;

  commit_trace #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .trace_ready(trace_ready), .trace_valid(trace_valid), .trace_kind(trace_kind),
    .trace_pc(trace_pc), .trace_dst(trace_dst), .trace_data(trace_data),
    .trace_ts(trace_ts), .count(count), .full(full), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  kind;
    logic [11:0] pc;
    logic [11:0] dst;
    logic [31:0] data;
    logic [15:0] ts;
  } entry_t;

  typedef struct {
    logic v, en;
    logic [11:0] pc;
    logic rwe;
    logic [4:0] rr;
    logic [31:0] rd;
    logic mwe;
    logic [11:0] ma;
    logic [31:0] md;
    logic rdy, clr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [4:0]  exp_count;
    logic [7:0]  exp_drop;
    logic [1:0]  exp_kind;
    logic [11:0] exp_dst;
    logic [31:0] exp_data;
  } vec_t;

  entry_t      q[$];
  entry_t      m_pend_e;
  logic        m_pend;
  logic [7:0]  m_drop;
  logic [15:0] tb_ts;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle(input logic rdy);
    stim_t s;
    s = '{1'b0, 1'b1, 12'h0, 1'b0, 5'd0, 32'h0, 1'b0, 12'h0, 32'h0, rdy, 1'b0};
    return s;
  endfunction

  function automatic stim_t memc(input logic [11:0] pc, input logic [11:0] a,
                                 input logic [31:0] d, input logic rdy);
    stim_t s;
    s = '{1'b1, 1'b1, pc, 1'b0, 5'd0, 32'h0, 1'b1, a, d, rdy, 1'b0};
    return s;
  endfunction

  function automatic stim_t clr();
    stim_t s;
    s = idle(1'b0);
    s.clr = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    commit_valid = s.v;  enable   = s.en;  commit_pc = s.pc;
    rf_we        = s.rwe; rf_reg  = s.rr;  rf_data   = s.rd;
    mem_we       = s.mwe; mem_addr = s.ma; mem_data  = s.md;
    trace_ready  = s.rdy; clear   = s.clr;
  endtask

  task automatic compare_outputs();
    entry_t h;
    h = '{2'b00, 12'h0, 12'h0, 32'h0, 16'h0};
    if (q.size() > 0) h = q[0];
    check("trace_valid", trace_valid, q.size() != 0);
    check("trace_kind",  trace_kind,  h.kind);
    check("trace_pc",    trace_pc,    h.pc);
    check("trace_dst",   trace_dst,   h.dst);
    check("trace_data",  trace_data,  h.data);
    check("trace_ts",    trace_ts,    h.ts);
    check("count",       count,       q.size());
    check("full",        full,        q.size() == DEPTH);
    check("drop_count",  drop_count,  m_drop);
  endtask

  // One clock: drive, let the edge happen, update the reference, then compare.
  task automatic step(input stim_t s);
    entry_t      e;
    logic        have, acc, hreg, pop;
    logic [15:0] cap;
    int          lost, nd;
    drive(s);
    @(posedge clock);
`ifdef COMMIT_TRACE_TS_EN
    cap = tb_ts;
`else
    cap = 16'h0;
`endif
    acc  = s.v && s.en;
    hreg = s.rwe && (s.rr != 5'd0);
    if (s.clr) begin
      q.delete();
      m_drop = 8'd0;
      m_pend = 1'b0;
    end else begin
      pop  = (q.size() > 0) && s.rdy;
      have = 1'b0;
      lost = 0;
      if (m_pend) begin
        e = m_pend_e; have = 1'b1; m_pend = 1'b0;
        if (acc && (hreg || s.mwe)) lost++;
      end else if (acc && hreg) begin
        e = '{2'b01, s.pc, {7'd0, s.rr}, s.rd, cap}; have = 1'b1;
        if (s.mwe) begin
          m_pend = 1'b1;
          m_pend_e = '{2'b10, s.pc, s.ma, s.md, cap};
        end
      end else if (acc && s.mwe) begin
        e = '{2'b10, s.pc, s.ma, s.md, cap}; have = 1'b1;
      end
      if (pop) void'(q.pop_front());
      if (have) begin
        if (q.size() == DEPTH) lost++;
        else q.push_back(e);
      end
      nd = int'(m_drop) + lost;
      m_drop = (nd > 255) ? 8'd255 : 8'(nd);
    end
    tb_ts = tb_ts + 16'd1;
    #1;
    compare_outputs();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] first_ts;
    drive(idle(1'b0));
    q.delete(); m_pend = 1'b0; m_drop = 8'd0; tb_ts = 16'd0;

    vecs[0]  = '{'{1'b1,1'b1,12'h004,1'b1,5'd3,32'h2A,1'b0,12'h0,32'h0,1'b0,1'b0}, 5'd1, 8'd0, 2'b01, 12'h003, 32'h2A};
    vecs[1]  = '{'{1'b1,1'b1,12'h006,1'b1,5'd0,32'h55,1'b0,12'h0,32'h0,1'b1,1'b0}, 5'd0, 8'd0, 2'b00, 12'h000, 32'h0};
    vecs[2]  = '{'{1'b1,1'b1,12'h008,1'b1,5'd5,32'h11,1'b1,12'h010,32'hDEADBEEF,1'b0,1'b0}, 5'd1, 8'd0, 2'b01, 12'h005, 32'h11};
    vecs[3]  = '{idle(1'b0), 5'd2, 8'd0, 2'b01, 12'h005, 32'h11};
    vecs[4]  = '{idle(1'b1), 5'd1, 8'd0, 2'b10, 12'h010, 32'hDEADBEEF};
    vecs[5]  = '{idle(1'b1), 5'd0, 8'd0, 2'b00, 12'h000, 32'h0};
    vecs[6]  = '{'{1'b1,1'b0,12'h00C,1'b0,5'd0,32'h0,1'b1,12'h020,32'h55,1'b0,1'b0}, 5'd0, 8'd0, 2'b00, 12'h000, 32'h0};
    vecs[7]  = '{'{1'b1,1'b1,12'h00C,1'b0,5'd0,32'h0,1'b1,12'h020,32'h55,1'b0,1'b0}, 5'd1, 8'd0, 2'b10, 12'h020, 32'h55};
    vecs[8]  = '{'{1'b1,1'b1,12'h010,1'b1,5'd7,32'h77,1'b1,12'h030,32'h88,1'b1,1'b0}, 5'd1, 8'd0, 2'b01, 12'h007, 32'h77};
    vecs[9]  = '{'{1'b1,1'b1,12'h014,1'b1,5'd1,32'h99,1'b0,12'h0,32'h0,1'b0,1'b0}, 5'd2, 8'd1, 2'b01, 12'h007, 32'h77};
    vecs[10] = '{idle(1'b1), 5'd1, 8'd1, 2'b10, 12'h030, 32'h88};
    vecs[11] = '{'{1'b1,1'b1,12'h018,1'b1,5'd2,32'hAA,1'b0,12'h0,32'h0,1'b1,1'b1}, 5'd0, 8'd0, 2'b00, 12'h000, 32'h0};

    // Reset state while reset is held.
    @(posedge clock); #1;
    compare_outputs();
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].s);
      check($sformatf("tbl%0d_count", i), count,      vecs[i].exp_count);
      check($sformatf("tbl%0d_drop",  i), drop_count, vecs[i].exp_drop);
      check($sformatf("tbl%0d_kind",  i), trace_kind, vecs[i].exp_kind);
      check($sformatf("tbl%0d_dst",   i), trace_dst,  vecs[i].exp_dst);
      check($sformatf("tbl%0d_data",  i), trace_data, vecs[i].exp_data);
    end

    // Overflow: 20 commits into a 16-deep FIFO with no consumer.
    for (int i = 0; i < 20; i++) step(memc(12'(i * 4), 12'(i), 32'(32'hA000 + i), 1'b0));
    check("ovf_full", full, 1'b1);
    check("ovf_count", count, 5'd16);
    check("ovf_drop", drop_count, 8'd4);

    // Full FIFO streaming: one push and one pop per edge.
    for (int i = 0; i < 20; i++) step(memc(12'(12'h100 + i), 12'(12'h200 + i), 32'(32'hB000 + i), 1'b1));
    check("stream_count", count, 5'd16);
    check("stream_drop", drop_count, 8'd4);

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) step(memc(12'(i), 12'(i), 32'(i), 1'b0));
    check("sat_drop", drop_count, 8'd255);

    // Clear with five entries held.
    step(clr());
    for (int i = 0; i < 5; i++) step(memc(12'(12'h300 + i), 12'(i), 32'(32'hC000 + i), 1'b0));
    check("pre_clear_count", count, 5'd5);
    step(clr());
    check("clear_count", count, 5'd0);
    check("clear_valid", trace_valid, 1'b0);

    // Reset in the middle of PEND drops the pending mem entry.
    step('{1'b1,1'b1,12'h040,1'b1,5'd9,32'h123,1'b1,12'h044,32'h456,1'b0,1'b0});
    check("pend_pre_valid", trace_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    q.delete(); m_pend = 1'b0; m_drop = 8'd0;
    compare_outputs();
    @(negedge clock);
    drive(idle(1'b0));
    tb_ts = 16'd0;
    reset = 1'b1;
    step(idle(1'b0));
    step(idle(1'b0));
    check("pend_reset_count", count, 5'd0);

`ifdef COMMIT_TRACE_TS_EN
    // Timestamp survives clear and wraps after 65536 clocks.
    step(memc(12'h050, 12'h051, 32'h52, 1'b0));
    step(clr());
    step(memc(12'h060, 12'h061, 32'h62, 1'b0));
    first_ts = tb_ts - 16'd1;
    check("ts_after_clear", trace_ts, first_ts);
    drive(idle(1'b0));
    repeat (65535) @(posedge clock);
    tb_ts = tb_ts + 16'd65535;
    #1;
    step(memc(12'h070, 12'h071, 32'h72, 1'b0));
    step(idle(1'b1));
    check("ts_wrap", trace_ts, first_ts);
`else
    first_ts = 16'h0;
    step(memc(12'h050, 12'h051, 32'h52, 1'b0));
    check("ts_const", trace_ts, first_ts);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
